// File: rtl/poc_alu_mux_a.sv
// ALU A operand source: IDR/MDR holding registers plus a 3-bit select mux with an error flag.
// Define POC_ALU_MUX_A_OUT_REG_EN to register alu_a/sel_err (one extra cycle of latency).
module poc_alu_mux_a #(
    parameter int DATA_W = 18,
    parameter int IDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_idr,
    input  logic [IDR_W-1:0]  din_idr,
    input  logic              write_mdr,
    input  logic [DATA_W-1:0] din_mdr,
    input  logic [DATA_W-1:0] dout_rcol,
    input  logic [DATA_W-1:0] dout_rrow,
    input  logic [2:0]        select,
    output logic [DATA_W-1:0] dout1_idr,
    output logic [IDR_W-1:0]  dout2_idr,
    output logic [DATA_W-1:0] dout_mdr,
    output logic [DATA_W-1:0] alu_a,
    output logic              sel_err
);

    logic [IDR_W-1:0]  idr_q, idr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] mux_d;
    logic              err_d;

    always_comb begin
        idr_d = write_idr ? din_idr : idr_q;
        mdr_d = write_mdr ? din_mdr : mdr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idr_q <= '0;
            mdr_q <= '0;
        end else begin
            idr_q <= idr_d;
            mdr_q <= mdr_d;
        end
    end

    assign dout1_idr = {{(DATA_W-IDR_W){1'b0}}, idr_q};
    assign dout2_idr = idr_q;
    assign dout_mdr  = mdr_q;

    // Row/column sources pass straight through, so they stay live even during reset.
    always_comb begin
        mux_d = '0;
        err_d = 1'b0;
        case (select)
            3'd0:    mux_d = '0;
            3'd1:    mux_d = dout1_idr;
            3'd2:    mux_d = mdr_q;
            3'd3:    mux_d = dout_rcol;
            3'd4:    mux_d = dout_rrow;
            default: begin
                mux_d = '0;
                err_d = 1'b1;
            end
        endcase
    end

`ifdef POC_ALU_MUX_A_OUT_REG_EN
    logic [DATA_W-1:0] alu_q;
    logic              err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q <= '0;
            err_q <= 1'b0;
        end else begin
            alu_q <= mux_d;
            err_q <= err_d;
        end
    end

    assign alu_a   = alu_q;
    assign sel_err = err_q;
`else
    assign alu_a   = mux_d;
    assign sel_err = err_d;
`endif

endmodule

// File: tb/tb_poc_alu_mux_a.sv
// Self-checking bench for poc_alu_mux_a (default combinational-output build).
module tb_poc_alu_mux_a;

    localparam int DW = 18;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write_idr;
    logic [IW-1:0] din_idr;
    logic          write_mdr;
    logic [DW-1:0] din_mdr;
    logic [DW-1:0] dout_rcol;
    logic [DW-1:0] dout_rrow;
    logic [2:0]    select;
    logic [DW-1:0] dout1_idr;
    logic [IW-1:0] dout2_idr;
    logic [DW-1:0] dout_mdr;
    logic [DW-1:0] alu_a;
    logic          sel_err;

    int checks = 0;
    int errors = 0;

    int unsigned m_idr;
    int unsigned m_mdr;

    poc_alu_mux_a #(.DATA_W(DW), .IDR_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write_idr (write_idr),
        .din_idr   (din_idr),
        .write_mdr (write_mdr),
        .din_mdr   (din_mdr),
        .dout_rcol (dout_rcol),
        .dout_rrow (dout_rrow),
        .select    (select),
        .dout1_idr (dout1_idr),
        .dout2_idr (dout2_idr),
        .dout_mdr  (dout_mdr),
        .alu_a     (alu_a),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we_i;
        logic [IW-1:0] di;
        logic          we_m;
        logic [DW-1:0] dm;
        logic [DW-1:0] rcol;
        logic [DW-1:0] rrow;
        logic [2:0]    sel;
        logic [DW-1:0] e_alu;
        logic          e_err;
        logic [DW-1:0] e_d1;
        logic [DW-1:0] e_mdr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: operand sources laid out as a table indexed by select.
    function automatic logic [DW-1:0] ref_alu(input int unsigned sel, input int unsigned idr,
                                              input int unsigned mdr, input int unsigned rc,
                                              input int unsigned rr);
        int unsigned src [8];
        src = '{0, idr, mdr, rc, rr, 0, 0, 0};
        return DW'(src[sel]);
    endfunction

    task automatic idle_inputs();
        write_idr = 1'b0;
        write_mdr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 9'd23,   1'b0, 18'd0,       18'd0,  18'd0,  3'd1, 18'd23,      1'b0, 18'd23,    18'd0};
        vecs[1]  = '{1'b0, 9'd0,    1'b1, 18'd19,      18'd0,  18'd0,  3'd2, 18'd19,      1'b0, 18'd23,    18'd19};
        vecs[2]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd3, 18'd65,      1'b0, 18'd23,    18'd19};
        vecs[3]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd4, 18'd54,      1'b0, 18'd23,    18'd19};
        vecs[4]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd0, 18'd0,       1'b0, 18'd23,    18'd19};
        vecs[5]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd6, 18'd0,       1'b1, 18'd23,    18'd19};
        vecs[6]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd1, 18'd23,      1'b0, 18'd23,    18'd19};
        vecs[7]  = '{1'b1, 9'h1FF,  1'b0, 18'd0,       18'd65, 18'd54, 3'd1, 18'h001FF,   1'b0, 18'h001FF, 18'd19};
        vecs[8]  = '{1'b1, 9'd5,    1'b1, 18'h3FFFF,   18'd65, 18'd54, 3'd2, 18'h3FFFF,   1'b0, 18'd5,     18'h3FFFF};
        vecs[9]  = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd5, 18'd0,       1'b1, 18'd5,     18'h3FFFF};
        vecs[10] = '{1'b0, 9'd0,    1'b0, 18'd0,       18'd65, 18'd54, 3'd7, 18'd0,       1'b1, 18'd5,     18'h3FFFF};

        rst_n     = 1'b0;
        write_idr = 1'b0;
        din_idr   = '0;
        write_mdr = 1'b0;
        din_mdr   = '0;
        dout_rcol = '0;
        dout_rrow = '0;
        select    = 3'd0;
        #12;
        chk("reset_d1",  32'(dout1_idr), 32'd0);
        chk("reset_d2",  32'(dout2_idr), 32'd0);
        chk("reset_mdr", 32'(dout_mdr),  32'd0);
        chk("reset_alu", 32'(alu_a),     32'd0);
        chk("reset_err", 32'(sel_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: apply on the falling edge, clock once, sample just after the rising edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            write_idr = vecs[i].we_i;
            din_idr   = vecs[i].di;
            write_mdr = vecs[i].we_m;
            din_mdr   = vecs[i].dm;
            dout_rcol = vecs[i].rcol;
            dout_rrow = vecs[i].rrow;
            select    = vecs[i].sel;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_alu", i), 32'(alu_a),     32'(vecs[i].e_alu));
            chk($sformatf("vec%0d_err", i), 32'(sel_err),   32'(vecs[i].e_err));
            chk($sformatf("vec%0d_d1",  i), 32'(dout1_idr), 32'(vecs[i].e_d1));
            chk($sformatf("vec%0d_d2",  i), 32'(dout2_idr), 32'(vecs[i].e_d1));
            chk($sformatf("vec%0d_mdr", i), 32'(dout_mdr),  32'(vecs[i].e_mdr));
            idle_inputs();
        end

        // Select change takes effect without a clock edge.
        @(negedge clk);
        select = 3'd3;
        #1 chk("comb_sel_rcol", 32'(alu_a), 32'd65);
        select = 3'd1;
        #1 chk("comb_sel_idr", 32'(alu_a), 32'd5);

        // Write-before-read: old value visible before the loading edge, new value right after.
        write_idr = 1'b1;
        din_idr   = 9'd77;
        #1 chk("wbr_before", 32'(alu_a), 32'd5);
        @(posedge clk);
        #1 chk("wbr_after", 32'(alu_a), 32'd77);
        @(negedge clk);
        write_idr = 1'b0;

        // Asynchronous reset mid-cycle, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mdr", 32'(dout_mdr),  32'd0);
        chk("arst_d1",  32'(dout1_idr), 32'd0);
        chk("arst_alu_sel1", 32'(alu_a), 32'd0);
        select = 3'd3;
        #1 chk("arst_rcol_pass", 32'(alu_a), 32'd65);
        select = 3'd4;
        #1 chk("arst_rrow_pass", 32'(alu_a), 32'd54);
        write_idr = 1'b1;
        din_idr   = 9'h055;
        write_mdr = 1'b1;
        din_mdr   = 18'h12345;
        @(posedge clk);
        #1;
        chk("arst_hold_d2",  32'(dout2_idr), 32'd0);
        chk("arst_hold_mdr", 32'(dout_mdr),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_release_no_load", 32'(dout2_idr), 32'd0);
        @(posedge clk);
        #1;
        chk("resume_d2",  32'(dout2_idr), 32'h055);
        chk("resume_mdr", 32'(dout_mdr),  32'h12345);
        m_idr = 32'h055;
        m_mdr = 32'h12345;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            write_idr = 1'($urandom_range(0, 1));
            din_idr   = IW'($urandom);
            write_mdr = 1'($urandom_range(0, 1));
            din_mdr   = DW'($urandom);
            dout_rcol = DW'($urandom);
            dout_rrow = DW'($urandom);
            select    = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_pre_alu", 32'(alu_a),
                32'(ref_alu(select, m_idr, m_mdr, dout_rcol, dout_rrow)));
            chk("rnd_pre_err", 32'(sel_err), (select > 3'd4) ? 32'd1 : 32'd0);
            if (write_idr) m_idr = din_idr;
            if (write_mdr) m_mdr = din_mdr;
            @(posedge clk);
            #1;
            chk("rnd_post_alu", 32'(alu_a),
                32'(ref_alu(select, m_idr, m_mdr, dout_rcol, dout_rrow)));
            chk("rnd_post_d1",  32'(dout1_idr), m_idr);
            chk("rnd_post_d2",  32'(dout2_idr), m_idr);
            chk("rnd_post_mdr", 32'(dout_mdr),  m_mdr);
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poc_alu_mux_a.md
POC_ALU_MUX_A -- requirements
Module: poc_alu_mux_a

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning width of the ALU A bus, MDR and row/column operands.
REQ-002 SHALL have parameter IDR_W, default 9, meaning width of the instruction-data register (IDR); IDR_W < DATA_W.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port write_idr, input, 1 bit, IDR load enable.
REQ-006 SHALL have port din_idr, input, IDR_W bits, IDR load data.
REQ-007 SHALL have port write_mdr, input, 1 bit, MDR load enable.
REQ-008 SHALL have port din_mdr, input, DATA_W bits, MDR load data.
REQ-009 SHALL have port dout_rcol, input, DATA_W bits, column register value.
REQ-010 SHALL have port dout_rrow, input, DATA_W bits, row register value.
REQ-011 SHALL have port select, input, 3 bits, ALU A source select.
REQ-012 SHALL have port dout1_idr, output, DATA_W bits, IDR zero-extended to DATA_W.
REQ-013 SHALL have port dout2_idr, output, IDR_W bits, raw IDR contents.
REQ-014 SHALL have port dout_mdr, output, DATA_W bits, MDR contents.
REQ-015 SHALL have port alu_a, output, DATA_W bits, selected ALU A operand.
REQ-016 SHALL have port sel_err, output, 1 bit, high while select is 5, 6 or 7.

Function
REQ-017 SHALL load IDR with din_idr on a rising clk edge when write_idr=1; otherwise hold.
REQ-018 SHALL load MDR with din_mdr on a rising clk edge when write_mdr=1; otherwise hold.
REQ-019 SHALL drive dout1_idr = {(DATA_W-IDR_W) zeros, IDR}, dout2_idr = IDR, dout_mdr = MDR, combinationally from register state.
REQ-020 SHALL decode select combinationally: 0 -> all zeros; 1 -> dout1_idr; 2 -> dout_mdr; 3 -> dout_rcol; 4 -> dout_rrow; 5-7 -> all zeros with sel_err=1.
REQ-021 SHALL present a register written at edge N on alu_a (if selected) immediately after edge N, i.e. zero added cycles beyond the register itself.
REQ-022 SHALL let a select change take effect on alu_a within the same cycle without waiting for a clock edge.
REQ-023 SHALL, when write_idr and write_mdr are both high, load both registers on the same edge independently.
REQ-024 SHALL give write-before-read semantics: alu_a shows old register contents before the loading edge and new contents after it.

Reset
REQ-025 SHALL clear IDR and MDR to 0 immediately when rst_n falls, independent of clk.
REQ-026 SHALL ignore write_idr and write_mdr while rst_n=0; loading resumes on the first rising clk edge after rst_n rises.
REQ-027 SHALL, during reset, drive dout1_idr=0, dout2_idr=0, dout_mdr=0, and alu_a per select (0 for selects 0-2, pass-through for 3-4).

Configuration
REQ-028 SHALL, when macro POC_ALU_MUX_A_OUT_REG_EN is defined, register alu_a and sel_err on rising clk (one-cycle latency from select or operand change, reset to 0 by rst_n).
REQ-029 SHALL, when POC_ALU_MUX_A_OUT_REG_EN is undefined, keep alu_a and sel_err purely combinational as in REQ-020.

Verification
REQ-030 SHALL cover: reset, then write_idr=1 din_idr=23 with one clock -> select=1 gives alu_a=23, dout2_idr=23.
REQ-031 SHALL cover: write_mdr=1 din_mdr=19 with one clock, select=2 -> alu_a=19.
REQ-032 SHALL cover: dout_rcol=65, dout_rrow=54; select=3 -> alu_a=65; select=4 -> alu_a=54; select=0 -> alu_a=0.
REQ-033 SHALL cover: select=6 -> alu_a=0 and sel_err=1; select=1 -> sel_err=0.
REQ-034 SHALL cover: din_idr=9'h1FF loaded -> dout1_idr=18'h001FF (zero-extend check).
REQ-035 SHALL cover: rst_n pulsed low mid-cycle after loads -> dout_mdr=0 and dout1_idr=0 before the next clk edge.
